sram_rw_arbiter: RTL

Controller that sequences a single-port 2048×5 SRAM macro (one shared read/write port, 1-cycle read latency). It shares the port between a read requester (lookup) and a write requester (update). It runs a post-reset initialization sweep and holds a one-entry write buffer with read bypass. It sits between predictor-table lookup/update logic and the SRAM wrapper.

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_wbuf.sv | 38 +++
 rtl/sram_rw_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the predictor-table SRAM arbiter.
package sram_arb_pkg;

  localparam int DEFAULT_ADDR_W    = 11;
  localparam int DEFAULT_DATA_W    = 5;
  localparam int DEFAULT_MAX_DEFER = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                      valid;
    logic [DEFAULT_ADDR_W-1:0] addr;
    logic [DEFAULT_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/sram_arb_wbuf.sv
// One-entry write buffer with an address comparator for read bypass.
module sram_arb_wbuf
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              hit
);

  // A load in a drain cycle simply replaces the entry being written out.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (load) begin
      wb_valid <= 1'b1;
      wb_addr  <= load_addr;
      wb_data  <= load_data;
    end else if (drain) begin
      wb_valid <= 1'b0;
    end
  end

  assign hit = wb_valid && (lookup_addr == wb_addr);

endmodule

// File: rtl/sram_rw_arbiter.sv
// Shares a single-port SRAM between lookup reads and buffered updates,
// after clearing the whole array with an initialization sweep.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          ADDR_W    = DEFAULT_ADDR_W,
  parameter int          DATA_W    = DEFAULT_DATA_W,
  parameter int          DEPTH     = 2048,
  parameter int unsigned INIT_VAL  = 0,
  parameter int          MAX_DEFER = DEFAULT_MAX_DEFER
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_addr,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [DATA_W-1:0] w_req_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int                DEFER_W   = $clog2(MAX_DEFER + 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);
  localparam logic [ADDR_W:0]    INIT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0]  INIT_DATA = DATA_W'(INIT_VAL);

  arb_state_t         state, next_state;
  logic [ADDR_W:0]    init_cnt;
  logic [DEFER_W-1:0] defer_cnt;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hit;

  logic drain, r_accept, r_hit, defer_inc, forced, w_accept;

  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [DATA_W-1:0] resp_data_q;

  assign forced   = wb_valid && (defer_cnt == DEFER_MAX);
  assign w_accept = w_req_valid && w_req_ready;

  sram_arb_wbuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clock      (clock),
    .reset      (reset),
    .load       (w_accept),
    .drain      (drain),
    .load_addr  (w_req_addr),
    .load_data  (w_req_data),
    .lookup_addr(r_req_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .hit        (wb_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      defer_cnt    <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state <= next_state;
      if (state == ST_INIT) init_cnt <= init_cnt + (ADDR_W + 1)'(1);
      if (drain) defer_cnt <= '0;
      else if (defer_inc && (defer_cnt != DEFER_MAX)) defer_cnt <= defer_cnt + DEFER_W'(1);
      resp_valid_q <= r_accept;
      resp_hit_q   <= r_hit;
      if (r_hit) resp_data_q <= wb_data;
    end
  end

  // Port decision: forced drain, read hit (bypass + drain), read miss, idle drain.
  always_comb begin
    next_state  = state;
    sram_en     = 1'b0;
    sram_wmode  = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    drain       = 1'b0;
    r_accept    = 1'b0;
    r_hit       = 1'b0;
    defer_inc   = 1'b0;
    r_req_ready = 1'b0;
    w_req_ready = 1'b0;
    if (!reset) begin
      if (state == ST_INIT) begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = init_cnt[ADDR_W-1:0];
        sram_wdata = INIT_DATA;
        if (init_cnt == INIT_LAST) next_state = ST_RUN;
      end else begin
        r_req_ready = !forced;
        if (forced) begin
          drain = 1'b1;
        end else if (r_req_valid && wb_hit) begin
          drain    = 1'b1;
          r_accept = 1'b1;
          r_hit    = 1'b1;
        end else if (r_req_valid) begin
          r_accept  = 1'b1;
          sram_en   = 1'b1;
          sram_addr = r_req_addr;
          defer_inc = wb_valid;
        end else if (wb_valid) begin
          drain = 1'b1;
        end
        if (drain) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = wb_addr;
          sram_wdata = wb_data;
        end
        w_req_ready = !wb_valid || drain;
      end
    end
  end

  assign init_done    = !reset && (state == ST_RUN);
  assign r_resp_valid = !reset && resp_valid_q;
  assign r_resp_data  = (!reset && resp_valid_q) ? (resp_hit_q ? resp_data_q : sram_rdata) : '0;

endmodule
